wr_addr_sequencer: RTL and testbench

//  Free-running write-address sequencer for the digitizer sample ring. Generates the

---
 rtl/wr_addr_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_wr_addr_sequencer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/wr_addr_sequencer.sv
// ---------------------------------------------------------------------------
// wr_addr_sequencer
//
// Free-running write-address sequencer for the digitizer sample ring. The
// write address is generated internally by a wrapping counter. The ring
// freezes a programmable number of addresses after a trigger. The trigger and
// stop addresses are reported to readout, and a resume strobe restarts the ring.
// The address is re-timed through a register pipeline. The last register of
// that pipeline drives the address pins directly, with no logic after it.
//
// Parameters
//   WIDTH      address width in bits
//   MAX_ADDR   last address before the counter wraps to 0 (< 2**WIDTH)
//   OUT_DELAY  register stages from the internal counter to wraddr_o (>= 1)
//
// Ports
//   clk_i        in   write clock, all logic on the rising edge
//   rst_i        in   asynchronous reset, active high
//   enable_i     in   level: 1 lets the sequencer run, 0 returns it to IDLE
//   trig_i       in   trigger strobe, only accepted in RUN
//   resume_i     in   strobe releasing HALT back to RUN
//   posttrig_i   in   post-trigger address count, captured on the trigger
//   wraddr_o     out  write address, counter delayed by OUT_DELAY cycles
//   running_o    out  1 while in RUN or POST
//   halted_o     out  1 while in HALT
//   trig_addr_o  out  counter value at the accepted trigger (binary)
//   stop_addr_o  out  counter value held in HALT (binary)
//
// Configuration macro
//   WRADDR_GRAY_EN  when defined, the final pipeline stage registers the Gray
//                   code of the address, so wraddr_o is Gray-coded with the
//                   same latency. trig_addr_o and stop_addr_o stay binary.
//                   When undefined, wraddr_o is plain binary.
// ---------------------------------------------------------------------------
module wr_addr_sequencer #(
    parameter int WIDTH     = 10,
    parameter int MAX_ADDR  = 1023,
    parameter int OUT_DELAY = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             enable_i,
    input  logic             trig_i,
    input  logic             resume_i,
    input  logic [WIDTH-1:0] posttrig_i,
    output logic [WIDTH-1:0] wraddr_o,
    output logic             running_o,
    output logic             halted_o,
    output logic [WIDTH-1:0] trig_addr_o,
    output logic [WIDTH-1:0] stop_addr_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        POST = 2'd2,
        HALT = 2'd3
    } state_t;

    state_t           state_q;
    state_t           state_nxt;
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_inc;
    logic [WIDTH-1:0] remain_q;
    logic [WIDTH-1:0] trig_addr_q;
    logic [WIDTH-1:0] stop_addr_q;
    logic             running_q;
    logic             halted_q;

    // The counter wraps explicitly at MAX_ADDR rather than relying on
    // overflow, so rings shorter than 2**WIDTH never emit out-of-range addresses.
    always_comb begin
        cnt_inc = (cnt_q == WIDTH'(MAX_ADDR)) ? '0 : cnt_q + WIDTH'(1);
    end

    // The next state is computed separately so that running/halted can be
    // registered from it. The flags then change on the same edge as the state register.
    // A low enable_i wins over every other condition.
    always_comb begin
        state_nxt = state_q;
        if (!enable_i) begin
            state_nxt = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_nxt = RUN;
                RUN:     if (trig_i) state_nxt = POST;
                POST:    if (remain_q == '0) state_nxt = HALT;
                HALT:    if (resume_i) state_nxt = RUN;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Main sequencer: state register, counter, post-trigger countdown and the
    // reported addresses. The counter still advances on the trigger cycle itself.
    // POST spends one extra cycle with remain==0 to latch the stop address.
    // This gives stop = trig + posttrig + 1 modulo the ring length.
    // Triggers outside RUN are dropped here, not queued.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            remain_q    <= '0;
            trig_addr_q <= '0;
            stop_addr_q <= '0;
            running_q   <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            running_q <= (state_nxt == RUN) || (state_nxt == POST);
            halted_q  <= (state_nxt == HALT);
            if (enable_i) begin
                case (state_q)
                    RUN: begin
                        cnt_q <= cnt_inc;
                        if (trig_i) begin
                            trig_addr_q <= cnt_q;
                            remain_q    <= posttrig_i;
                        end
                    end
                    POST: begin
                        if (remain_q != '0) begin
                            cnt_q    <= cnt_inc;
                            remain_q <= remain_q - WIDTH'(1);
                        end else begin
                            stop_addr_q <= cnt_q;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // Output re-timing. Every stage shifts on every cycle, so wraddr_o settles
    // on the held counter value OUT_DELAY cycles after the counter stops.
    // The optional Gray encode sits in front of the final register, not after it.
    // This keeps the pin register free of logic.
    logic [WIDTH-1:0] last_in;
    logic [WIDTH-1:0] last_enc;
    logic [WIDTH-1:0] wraddr_q;

    generate
        if (OUT_DELAY == 1) begin : g_direct
            assign last_in = cnt_q;
        end else begin : g_chain
            logic [WIDTH-1:0] mid_q [OUT_DELAY-1];

            // Intermediate delay stages between the counter and the pin register.
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    for (int i = 0; i < OUT_DELAY - 1; i++) begin
                        mid_q[i] <= '0;
                    end
                end else begin
                    mid_q[0] <= cnt_q;
                    for (int i = 1; i < OUT_DELAY - 1; i++) begin
                        mid_q[i] <= mid_q[i-1];
                    end
                end
            end

            assign last_in = mid_q[OUT_DELAY-2];
        end
    endgenerate

`ifdef WRADDR_GRAY_EN
    assign last_enc = last_in ^ (last_in >> 1);
`else
    assign last_enc = last_in;
`endif

    // Final pin register. Nothing sits between it and wraddr_o, so it can be
    // packed into the I/O block.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wraddr_q <= '0;
        end else begin
            wraddr_q <= last_enc;
        end
    end

    assign wraddr_o    = wraddr_q;
    assign running_o   = running_q;
    assign halted_o    = halted_q;
    assign trig_addr_o = trig_addr_q;
    assign stop_addr_o = stop_addr_q;

endmodule

// File: tb/tb_wr_addr_sequencer.sv
// ---------------------------------------------------------------------------
// tb_wr_addr_sequencer
//
// Directed testbench for wr_addr_sequencer. Its main instance uses the default
// 1024-entry ring with OUT_DELAY=2. The second instance has MAX_ADDR=511 and
// exercises the short-ring wrap and the 7->8 output encoding. Inputs change
// 1 ns after a rising edge, and outputs are sampled at the same point.
// ---------------------------------------------------------------------------
module tb_wr_addr_sequencer;

    localparam int WIDTH = 10;

    logic             clk;
    logic             rst;
    logic             enable;
    logic             trig;
    logic             resume;
    logic [WIDTH-1:0] posttrig;
    logic [WIDTH-1:0] wraddr;
    logic             running;
    logic             halted;
    logic [WIDTH-1:0] trig_addr;
    logic [WIDTH-1:0] stop_addr;

    logic             en_small;
    logic [WIDTH-1:0] wraddr_small;
    logic             running_small;
    logic             halted_small;
    logic [WIDTH-1:0] trig_addr_small;
    logic [WIDTH-1:0] stop_addr_small;

    int checks   = 0;
    int failures = 0;

    wr_addr_sequencer #(.WIDTH(WIDTH), .MAX_ADDR(1023), .OUT_DELAY(2)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .enable_i    (enable),
        .trig_i      (trig),
        .resume_i    (resume),
        .posttrig_i  (posttrig),
        .wraddr_o    (wraddr),
        .running_o   (running),
        .halted_o    (halted),
        .trig_addr_o (trig_addr),
        .stop_addr_o (stop_addr)
    );

    wr_addr_sequencer #(.WIDTH(WIDTH), .MAX_ADDR(511), .OUT_DELAY(2)) dut_small (
        .clk_i       (clk),
        .rst_i       (rst),
        .enable_i    (en_small),
        .trig_i      (1'b0),
        .resume_i    (1'b0),
        .posttrig_i  ('0),
        .wraddr_o    (wraddr_small),
        .running_o   (running_small),
        .halted_o    (halted_small),
        .trig_addr_o (trig_addr_small),
        .stop_addr_o (stop_addr_small)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected pin value for a binary counter value under the current build.
    function automatic logic [WIDTH-1:0] exp_wr(input int bin);
        logic [WIDTH-1:0] b;
        b = WIDTH'(bin);
`ifdef WRADDR_GRAY_EN
        return b ^ (b >> 1);
`else
        return b;
`endif
    endfunction

    // Advance n rising edges and land 1 ns after the last one.
    task automatic apply_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs,
                                input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst      = 1'b1;
        enable   = 1'b0;
        trig     = 1'b0;
        resume   = 1'b0;
        posttrig = '0;
        en_small = 1'b0;
        apply_cycles(2);

        check_output("rst_wraddr",    32'(wraddr),    0);
        check_output("rst_running",   32'(running),   0);
        check_output("rst_halted",    32'(halted),    0);
        check_output("rst_trig_addr", 32'(trig_addr), 0);
        check_output("rst_stop_addr", 32'(stop_addr), 0);
        check_output("rst_small_wr",  32'(wraddr_small), 0);

        // Run up to cnt=37, then reset asynchronously between edges
        rst    = 1'b0;
        enable = 1'b1;
        apply_cycles(1);
        check_output("run_entered", 32'(running), 1);
        apply_cycles(37);
        check_output("wraddr_cnt37", 32'(wraddr), 35);
        #2 rst = 1'b1;
        #1;
        check_output("async_rst_wraddr",  32'(wraddr),  0);
        check_output("async_rst_running", 32'(running), 0);
        apply_cycles(1);
        rst = 1'b0;
        apply_cycles(4);
        check_output("restart_wr1", 32'(wraddr), 1);
        apply_cycles(1);
        check_output("restart_wr2", 32'(wraddr), 2);
        apply_cycles(1);
        check_output("restart_wr3", 32'(wraddr), 3);

        // Trigger at cnt=5 with posttrig=3; a later posttrig change is ignored
        trig     = 1'b1;
        posttrig = 10'd3;
        apply_cycles(1);
        trig     = 1'b0;
        posttrig = 10'd100;
        check_output("trig_addr_5",  32'(trig_addr), 5);
        check_output("post_running", 32'(running),   1);
        apply_cycles(4);
        check_output("stop_addr_9",  32'(stop_addr), 9);
        check_output("halted_9",     32'(halted),    1);
        check_output("halt_running", 32'(running),   0);
        apply_cycles(2);
        check_output("wraddr_hold_9", 32'(wraddr), 9);

        // Resume and trigger together in HALT: resume wins
        resume = 1'b1;
        trig   = 1'b1;
        apply_cycles(1);
        resume = 1'b0;
        trig   = 1'b0;
        check_output("resume_running", 32'(running),   1);
        check_output("resume_halted",  32'(halted),    0);
        check_output("resume_trig_kept", 32'(trig_addr), 5);

        // Trigger at 100 with posttrig=0 stops at 101
        apply_cycles(91);
        trig     = 1'b1;
        posttrig = 10'd0;
        apply_cycles(1);
        trig = 1'b0;
        apply_cycles(1);
        check_output("trig_addr_100", 32'(trig_addr), 100);
        check_output("stop_addr_101", 32'(stop_addr), 101);
        check_output("halted_101",    32'(halted),    1);

        // Trigger in HALT is ignored
        trig = 1'b1;
        apply_cycles(2);
        trig = 1'b0;
        check_output("halt_trig_ignored", 32'(halted),    1);
        check_output("halt_trig_addr",    32'(trig_addr), 100);

        // Resume, trigger at 101 with posttrig=5, then drop enable in POST
        resume = 1'b1;
        apply_cycles(1);
        resume   = 1'b0;
        trig     = 1'b1;
        posttrig = 10'd5;
        apply_cycles(1);
        trig = 1'b0;
        apply_cycles(3);
        enable = 1'b0;
        apply_cycles(1);
        check_output("idle_running", 32'(running), 0);
        check_output("idle_halted",  32'(halted),  0);
        trig = 1'b1;
        apply_cycles(2);
        trig = 1'b0;
        apply_cycles(2);
        check_output("idle_wraddr_frozen", 32'(wraddr),    105);
        check_output("idle_trig_addr",     32'(trig_addr), 101);
        check_output("idle_stop_addr",     32'(stop_addr), 101);
        check_output("idle_trig_ignored",  32'(running),   0);

        // Re-enable from 105 and trigger at 1021 with posttrig=4: wraps to stop at 2
        enable = 1'b1;
        apply_cycles(1);
        check_output("reenable_running", 32'(running), 1);
        apply_cycles(916);
        trig     = 1'b1;
        posttrig = 10'd4;
        apply_cycles(1);
        trig = 1'b0;
        apply_cycles(5);
        check_output("wrap_trig_addr", 32'(trig_addr), 1021);
        check_output("wrap_stop_addr", 32'(stop_addr), 2);
        check_output("wrap_halted",    32'(halted),    1);

        // Short ring (MAX_ADDR=511): 7->8 encoding and the 511->0 wrap
        en_small = 1'b1;
        apply_cycles(1);
        apply_cycles(9);
        check_output("small_wr7", 32'(wraddr_small), 32'(exp_wr(7)));
        apply_cycles(1);
        check_output("small_wr8", 32'(wraddr_small), 32'(exp_wr(8)));
        apply_cycles(502);
        check_output("small_wr510", 32'(wraddr_small), 32'(exp_wr(510)));
        apply_cycles(1);
        check_output("small_wr511", 32'(wraddr_small), 32'(exp_wr(511)));
        apply_cycles(1);
        check_output("small_wr0",   32'(wraddr_small), 32'(exp_wr(0)));
        apply_cycles(1);
        check_output("small_wr1",   32'(wraddr_small), 32'(exp_wr(1)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
